// File: rtl/z80_mem_responder_if.sv
// CPU-side bus bundle for the Z80 memory responder. The CPU (or a bench
// standing in for it) uses the master view; the responder uses the slave view.
interface z80_mem_responder_if;
    logic [15:0] addr_in;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        drive_data;
    logic        MREQ_L;
    logic        RD_L;
    logic        WR_L;
    logic        M1_L;
    logic        RFSH_L;
    logic        WAIT_L;

    modport master (
        output addr_in, data_in, MREQ_L, RD_L, WR_L, M1_L, RFSH_L,
        input  data_out, drive_data, WAIT_L
    );

    modport slave (
        input  addr_in, data_in, MREQ_L, RD_L, WR_L, M1_L, RFSH_L,
        output data_out, drive_data, WAIT_L
    );
endinterface

// File: rtl/z80_mem_responder.sv
// Memory-side responder for the Z80 external bus: answers opcode/data reads,
// commits writes, optionally stretches accesses with WAIT_L, and takes program
// images through a backdoor write port.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | no access in flight; strobes sampled here only
// S_WAITING  | WAIT_L held low, counting down the configured wait states
// S_RD_DRIVE | read data on the bus; stays while RD_L is low
// S_RD_HOLD  | one extra drive cycle so the CPU can latch in T3
// S_WR_DONE  | write committed; waiting for WR_L to return high
module z80_mem_responder #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst_L,
    z80_mem_responder_if.slave    bus,
    input  logic                  load_en,
    input  logic [ADDR_W-1:0]     load_addr,
    input  logic [7:0]            load_data,
    output logic [15:0]           fetch_count,
    output logic                  err
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAITING,
        S_RD_DRIVE,
        S_RD_HOLD,
        S_WR_DONE
    } state_t;

    logic [7:0] mem [0:DEPTH-1];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              is_wr_q, is_wr_d;
    logic              m1_q, m1_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [7:0]        data_out_q, data_out_d;
    logic              drive_q, drive_d;
    logic              wait_l_q, wait_l_d;
    logic              err_q, err_d;
    logic [15:0]       fetch_count_q, fetch_count_d;

    logic [ADDR_W-1:0] addr_lo;
    logic              rd_req;
    logic              wr_req;
    logic              rd_wr_clash;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;

    // Upper address bits alias onto the implemented range.
    assign addr_lo = bus.addr_in[ADDR_W-1:0];

    generate
        if (ADDR_W < 16) begin : g_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^bus.addr_in[15:ADDR_W];
        end
    endgenerate

    assign rd_req      = !bus.MREQ_L && !bus.RD_L && bus.WR_L && bus.RFSH_L;
    assign wr_req      = !bus.MREQ_L && !bus.WR_L && bus.RD_L && bus.RFSH_L;
    assign rd_wr_clash = !bus.RD_L && !bus.WR_L;

    // Next-state, next-output and write-commit decode for the access FSM.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        is_wr_d       = is_wr_q;
        m1_d          = m1_q;
        wait_cnt_d    = wait_cnt_q;
        data_out_d    = data_out_q;
        drive_d       = drive_q;
        wait_l_d      = wait_l_q;
        err_d         = 1'b0;
        fetch_count_d = fetch_count_q;
        mem_we        = 1'b0;
        mem_waddr     = addr_q;

        case (state_q)
            S_IDLE: begin
                drive_d  = 1'b0;
                wait_l_d = 1'b1;
                if (rd_wr_clash) begin
                    err_d = 1'b1;
                end else if (rd_req) begin
                    addr_d  = addr_lo;
                    is_wr_d = 1'b0;
                    m1_d    = bus.M1_L;
                    if (WAIT_CYCLES > 0) begin
                        state_d    = S_WAITING;
                        wait_cnt_d = WAIT_INIT;
                        wait_l_d   = 1'b0;
                    end else begin
                        state_d    = S_RD_DRIVE;
                        data_out_d = mem[addr_lo];
                        drive_d    = 1'b1;
                    end
                end else if (wr_req) begin
                    addr_d  = addr_lo;
                    is_wr_d = 1'b1;
                    m1_d    = bus.M1_L;
                    if (WAIT_CYCLES > 0) begin
                        state_d    = S_WAITING;
                        wait_cnt_d = WAIT_INIT;
                        wait_l_d   = 1'b0;
                    end else begin
                        // Zero-wait writes commit on the sampling edge itself.
                        mem_we    = 1'b1;
                        mem_waddr = addr_lo;
                        state_d   = S_WR_DONE;
                    end
                end
            end

            S_WAITING: begin
                if (bus.MREQ_L) begin
                    // CPU walked away mid-wait: drop it, nothing committed.
                    state_d    = S_IDLE;
                    wait_l_d   = 1'b1;
                    wait_cnt_d = 4'd0;
                end else if (wait_cnt_q <= 4'd1) begin
                    wait_l_d   = 1'b1;
                    wait_cnt_d = 4'd0;
                    if (is_wr_q) begin
                        mem_we  = 1'b1;
                        state_d = S_WR_DONE;
                    end else begin
                        data_out_d = mem[addr_q];
                        drive_d    = 1'b1;
                        state_d    = S_RD_DRIVE;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end

            S_RD_DRIVE: begin
                if (bus.RD_L) begin
                    state_d = S_RD_HOLD;
                    if (!m1_q) begin
                        fetch_count_d = fetch_count_q + 16'd1;
                    end
                end
            end

            S_RD_HOLD: begin
                state_d = S_IDLE;
                drive_d = 1'b0;
            end

            S_WR_DONE: begin
                if (bus.WR_L) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d  = S_IDLE;
                drive_d  = 1'b0;
                wait_l_d = 1'b1;
            end
        endcase
    end

    // Access FSM state and registered bus outputs; reset aborts any access.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            is_wr_q       <= 1'b0;
            m1_q          <= 1'b1;
            wait_cnt_q    <= 4'd0;
            data_out_q    <= 8'h00;
            drive_q       <= 1'b0;
            wait_l_q      <= 1'b1;
            err_q         <= 1'b0;
            fetch_count_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            is_wr_q       <= is_wr_d;
            m1_q          <= m1_d;
            wait_cnt_q    <= wait_cnt_d;
            data_out_q    <= data_out_d;
            drive_q       <= drive_d;
            wait_l_q      <= wait_l_d;
            err_q         <= err_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Memory array: bus commit first, backdoor second so it wins a collision.
    always_ff @(posedge clk) begin
        if (mem_we && rst_L) begin
            mem[mem_waddr] <= bus.data_in;
        end
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.drive_data = drive_q;
    assign bus.WAIT_L     = wait_l_q;
    assign fetch_count    = fetch_count_q;
    assign err            = err_q;

endmodule

// File: tb/tb_z80_mem_responder.sv
// Directed bench for z80_mem_responder: a zero-wait instance and a
// three-wait instance share clock, reset and backdoor port.
module tb_z80_mem_responder;

    logic        clk;
    logic        rst_L;
    logic        load_en;
    logic [11:0] load_addr;
    logic [7:0]  load_data;
    logic [15:0] fc0, fcw;
    logic        err0, errw;

    int n_tests = 0;
    int n_fail  = 0;

    z80_mem_responder_if bus0 ();
    z80_mem_responder_if busw ();

    z80_mem_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_L(rst_L), .bus(bus0),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .fetch_count(fc0), .err(err0)
    );

    z80_mem_responder #(.ADDR_W(12), .WAIT_CYCLES(3)) dutw (
        .clk(clk), .rst_L(rst_L), .bus(busw),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .fetch_count(fcw), .err(errw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        mreq, rd, wr, rfsh, m1;
        logic [15:0] addr;
        logic [7:0]  din;
        logic        exp_drv;
        logic        exp_err;
        logic [7:0]  exp_dout;
        logic [15:0] exp_fc;
    } vec_t;

    vec_t tv [10];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input bit w, input logic mreq, input logic rd, input logic wr,
                           input logic m1, input logic rfsh, input logic [15:0] a,
                           input logic [7:0] d);
        if (w) begin
            busw.MREQ_L = mreq; busw.RD_L = rd; busw.WR_L = wr;
            busw.M1_L = m1; busw.RFSH_L = rfsh; busw.addr_in = a; busw.data_in = d;
        end else begin
            bus0.MREQ_L = mreq; bus0.RD_L = rd; bus0.WR_L = wr;
            bus0.M1_L = m1; bus0.RFSH_L = rfsh; bus0.addr_in = a; bus0.data_in = d;
        end
    endtask

    task automatic idle_bus(input bit w);
        set_bus(w, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
    endtask

    function automatic logic drv(input bit w);
        return w ? busw.drive_data : bus0.drive_data;
    endfunction

    function automatic logic waitl(input bit w);
        return w ? busw.WAIT_L : bus0.WAIT_L;
    endfunction

    function automatic logic [7:0] dout(input bit w);
        return w ? busw.data_out : bus0.data_out;
    endfunction

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    // Read access; checks the byte and that drive covers exactly two cycles.
    task automatic bus_read(input bit w, input logic [15:0] a, input logic m1,
                            input logic [7:0] exp, input string name);
        int n;
        check({name, "_pre_drv"}, 16'(drv(w)), 16'd0);
        set_bus(w, 1'b0, 1'b0, 1'b1, m1, 1'b1, a, 8'h00);
        tick();
        n = 0;
        while (!drv(w) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            check({name, "_timeout"}, 16'(n), 16'd0);
            idle_bus(w);
            tick(); tick();
        end else begin
            idle_bus(w);
            check({name, "_data"}, 16'(dout(w)), 16'(exp));
            tick();
            check({name, "_hold_drv"}, 16'(drv(w)), 16'd1);
            check({name, "_hold_data"}, 16'(dout(w)), 16'(exp));
            tick();
            check({name, "_release"}, 16'(drv(w)), 16'd0);
        end
    endtask

    initial begin
        rst_L = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        idle_bus(1'b0);
        idle_bus(1'b1);

        tv[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0123, 8'hA5, 1'b0, 1'b0, 8'h00, 16'd2};
        tv[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0123, 8'h00, 1'b1, 1'b0, 8'hA5, 16'd2};
        tv[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0042, 8'hEE, 1'b0, 1'b0, 8'h00, 16'd2};
        tv[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0042, 8'hEE, 1'b0, 1'b1, 8'h00, 16'd2};
        tv[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0042, 8'h00, 1'b1, 1'b0, 8'h99, 16'd3};
        tv[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'hF0AA, 8'h3C, 1'b0, 1'b0, 8'h00, 16'd3};
        tv[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h00AA, 8'h00, 1'b1, 1'b0, 8'h3C, 16'd4};
        tv[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 8'h3C, 16'd5};
        tv[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 16'd5};
        tv[9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 16'd5};

        // Reset values, sampled while reset is held.
        #12;
        check("rst_dout", 16'(bus0.data_out), 16'h0000);
        check("rst_drv", 16'(bus0.drive_data), 16'd0);
        check("rst_waitl", 16'(bus0.WAIT_L), 16'd1);
        check("rst_err", 16'(err0), 16'd0);
        check("rst_fc", fc0, 16'h0000);
        check("rst_waitl_w", 16'(busw.WAIT_L), 16'd1);
        rst_L = 1'b1;
        tick();

        preload(12'h000, 8'h3C);
        preload(12'h001, 8'h00);
        preload(12'h010, 8'h77);
        preload(12'h042, 8'h99);
        preload(12'h050, 8'h11);
        preload(12'h060, 8'h33);
        tick();

        // Two opcode fetches: drive T2..T3, released at T3/T4.
        bus_read(1'b0, 16'h0000, 1'b0, 8'h3C, "fetch0");
        bus_read(1'b0, 16'h0001, 1'b0, 8'h00, "fetch1");
        check("fetch_count2", fc0, 16'd2);

        // Single-access vectors on the zero-wait instance.
        for (int i = 0; i < 10; i++) begin
            set_bus(1'b0, tv[i].mreq, tv[i].rd, tv[i].wr, tv[i].m1, tv[i].rfsh,
                    tv[i].addr, tv[i].din);
            tick();
            check($sformatf("vec%0d_err", i), 16'(err0), 16'(tv[i].exp_err));
            check($sformatf("vec%0d_drv", i), 16'(bus0.drive_data), 16'(tv[i].exp_drv));
            if (tv[i].exp_drv)
                check($sformatf("vec%0d_data", i), 16'(bus0.data_out), 16'(tv[i].exp_dout));
            idle_bus(1'b0);
            tick();
            check($sformatf("vec%0d_err_pulse", i), 16'(err0), 16'd0);
            tick();
            tick();
            check($sformatf("vec%0d_fc", i), fc0, tv[i].exp_fc);
        end

        // Aliasing: 0xF123 lands on 0x123.
        preload(12'h123, 8'h5E);
        bus_read(1'b0, 16'hF123, 1'b1, 8'h5E, "alias");
        check("alias_fc", fc0, 16'd5);

        // Backdoor beats a bus commit on the same edge and address.
        set_bus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0300, 8'hAA);
        load_en = 1'b1; load_addr = 12'h300; load_data = 8'hBB;
        tick();
        load_en = 1'b0;
        idle_bus(1'b0);
        tick(); tick();
        bus_read(1'b0, 16'h0300, 1'b1, 8'hBB, "collide");

        // Three wait states on a read of 0x010.
        set_bus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0010, 8'h00);
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("wait%0d_waitl", i), 16'(busw.WAIT_L), 16'd0);
            check($sformatf("wait%0d_drv", i), 16'(busw.drive_data), 16'd0);
            tick();
        end
        check("wait_end_waitl", 16'(busw.WAIT_L), 16'd1);
        check("wait_end_drv", 16'(busw.drive_data), 16'd1);
        check("wait_end_data", 16'(busw.data_out), 16'h0077);
        idle_bus(1'b1);
        tick();
        check("wait_hold_drv", 16'(busw.drive_data), 16'd1);
        tick();
        check("wait_release", 16'(busw.drive_data), 16'd0);
        check("wait_fc", fcw, 16'd1);

        // Strobes vanish mid-wait: write to 0x060 is abandoned.
        set_bus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0060, 8'h44);
        tick();
        check("abandon_waitl_lo", 16'(waitl(1'b1)), 16'd0);
        idle_bus(1'b1);
        tick();
        check("abandon_waitl_hi", 16'(waitl(1'b1)), 16'd1);
        check("abandon_drv", 16'(drv(1'b1)), 16'd0);
        tick();
        bus_read(1'b1, 16'h0060, 1'b1, 8'h33, "abandon_mem");

        // Reset during WAITING of a write to 0x050.
        set_bus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0050, 8'h22);
        tick();
        tick();
        #2 rst_L = 1'b0;
        #1;
        check("rstw_waitl", 16'(busw.WAIT_L), 16'd1);
        check("rstw_drv", 16'(busw.drive_data), 16'd0);
        check("rstw_fc", fcw, 16'd0);
        tick(); tick();
        idle_bus(1'b1);
        tick();
        rst_L = 1'b1;
        tick();
        bus_read(1'b1, 16'h0050, 1'b1, 8'h11, "rstw_mem");

        // Reset during RD_DRIVE.
        set_bus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 8'h00);
        tick();
        check("rstr_pre_drv", 16'(bus0.drive_data), 16'd1);
        #2 rst_L = 1'b0;
        #1;
        check("rstr_drv", 16'(bus0.drive_data), 16'd0);
        check("rstr_dout", 16'(bus0.data_out), 16'h0000);
        check("rstr_fc", fc0, 16'h0000);
        idle_bus(1'b0);
        tick();
        rst_L = 1'b1;
        tick();

        // 65537 fetches wrap the counter to 1.
        for (int i = 0; i < 65537; i++) begin
            set_bus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'(i), 8'h00);
            tick();
            idle_bus(1'b0);
            tick();
            tick();
            if (i == 65534) check("fc_ffff", fc0, 16'hFFFF);
        end
        check("fc_wrap", fc0, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
